// File: rtl/vic_dram_seq_pkg.sv
// Shared definitions for the VIC address generator / DRAM sequencer:
// cycle-type encodings, default DRAM timing, sequencer states and helpers.
package vic_dram_seq_pkg;

    // VIC cycle-type encodings driven by the cycle sequencer
    localparam logic [3:0] VIC_LP  = 4'd0;   // sprite pointer fetch
    localparam logic [3:0] VIC_LS2 = 4'd1;   // sprite data byte 2
    localparam logic [3:0] VIC_LR  = 4'd2;   // DRAM refresh
    localparam logic [3:0] VIC_LG  = 4'd3;   // graphics fetch
    localparam logic [3:0] VIC_HS1 = 4'd4;   // sprite data byte 1
    localparam logic [3:0] VIC_HS3 = 4'd5;   // sprite data byte 3
    localparam logic [3:0] VIC_HRC = 4'd6;   // matrix fetch, colour
    localparam logic [3:0] VIC_HGC = 4'd7;   // matrix fetch, graphics
    localparam logic [3:0] VIC_HI  = 4'd8;   // idle, high phase
    localparam logic [3:0] VIC_LI  = 4'd9;   // idle, low phase

    // Default DRAM timing, in dot4x ticks from the start of a PHI half
    localparam int T_ROW_DEF = 2;
    localparam int T_RAS_DEF = 5;
    localparam int T_MUX_DEF = 6;
    localparam int T_CAS_DEF = 7;
    localparam int T_REL_DEF = 14;

    // Address driven when the VIC has nothing better to fetch
    localparam logic [13:0] ADDR_IDLE     = 14'h3FFF;
    localparam logic [13:0] ADDR_IDLE_ECM = 14'h39FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_RAS,
        S_COL,
        S_CAS,
        S_HOLD
    } seq_state_e;

    // Column byte presented on ado[7:0] once the row has been strobed
    function automatic logic [7:0] col_byte(input logic [13:0] a);
        return {a[7:6], a[13:8]};
    endfunction

endpackage

// File: rtl/vic_addr_compose.sv
// Combinational 14-bit VIC address mux: selects the fetch address from the
// cycle type and video state, and unflattens the per-sprite pointer/MC buses.
module vic_addr_compose
    import vic_dram_seq_pkg::*;
#(
    parameter int NUM_SPRITES = 8,
    parameter int SPR_IDX_W   = 3
) (
    input  logic [3:0]               cycle_type,
    input  logic [2:0]               cb,
    input  logic [3:0]               vm,
    input  logic [9:0]               vc,
    input  logic [2:0]               rc,
    input  logic [7:0]               refc,
    input  logic [7:0]               char_ptr,
    input  logic                     bmm,
    input  logic                     ecm,
    input  logic                     idle,
    input  logic                     aec,
    input  logic [SPR_IDX_W-1:0]     sprite_cnt,
    input  logic [NUM_SPRITES*8-1:0] sprite_ptr_o,
    input  logic [NUM_SPRITES*6-1:0] sprite_mc_o,
    output logic [13:0]              addr
);

    logic [7:0] ptr_arr [NUM_SPRITES];
    logic [5:0] mc_arr  [NUM_SPRITES];

    // Sprite 0 sits in the MSBs of the flattened buses
    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_unflat
            assign ptr_arr[gi] = sprite_ptr_o[(NUM_SPRITES-1-gi)*8 +: 8];
            assign mc_arr[gi]  = sprite_mc_o[(NUM_SPRITES-1-gi)*6 +: 6];
        end
    endgenerate

    logic        spr_ok;
    logic [2:0]  lp_idx;
    logic [13:0] gfx_addr;

    // Address selection by cycle type; out-of-range sprite indices fall back to idle
    always_comb begin
        spr_ok   = int'(sprite_cnt) < NUM_SPRITES;
        lp_idx   = 3'(sprite_cnt);
        gfx_addr = bmm ? {cb[2], vc, rc} : {cb, char_ptr, rc};
        if (ecm) begin
            gfx_addr[10:9] = 2'b00;
        end
        addr = ADDR_IDLE;
        case (cycle_type)
            VIC_LR: addr = {6'h3F, refc};
            VIC_LG: begin
                if (idle) begin
                    addr = ecm ? ADDR_IDLE_ECM : ADDR_IDLE;
                end else begin
                    addr = gfx_addr;
                end
            end
            VIC_HRC, VIC_HGC: addr = {vm, vc};
            VIC_LP: begin
                if (spr_ok) begin
                    addr = {vm, 7'h7F, lp_idx};
                end
            end
            VIC_HS1, VIC_LS2, VIC_HS3: begin
                if (spr_ok && !aec) begin
                    addr = {ptr_arr[sprite_cnt], mc_arr[sprite_cnt]};
                end
            end
            default: addr = ADDR_IDLE;
        endcase
    end

endmodule

// File: rtl/vic_dram_seq.sv
// VIC address generator with an internal DRAM sequencer: a dot4x tick counter
// per PHI half drives RAS/CAS and the row/column address mux.
module vic_dram_seq
    import vic_dram_seq_pkg::*;
#(
    parameter int NUM_SPRITES      = 8,
    parameter int SPR_IDX_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    parameter int ADO_W            = 12,
    parameter int T_ROW            = T_ROW_DEF,
    parameter int T_RAS            = T_RAS_DEF,
    parameter int T_MUX            = T_MUX_DEF,
    parameter int T_CAS            = T_CAS_DEF,
    parameter int T_REL            = T_REL_DEF,
    parameter int RAS_ONLY_REFRESH = 1
) (
    input  logic                     clk_dot4x,
    input  logic                     rst,
    input  logic                     phi_phase_start,
    input  logic [3:0]               cycle_type,
    input  logic [2:0]               cb,
    input  logic [3:0]               vm,
    input  logic [9:0]               vc,
    input  logic [2:0]               rc,
    input  logic [7:0]               refc,
    input  logic [7:0]               char_ptr,
    input  logic                     bmm,
    input  logic                     ecm,
    input  logic                     idle,
    input  logic                     aec,
    input  logic [SPR_IDX_W-1:0]     sprite_cnt,
    input  logic [NUM_SPRITES*8-1:0] sprite_ptr_o,
    input  logic [NUM_SPRITES*6-1:0] sprite_mc_o,
    output logic [ADO_W-1:0]         ado,
    output logic                     ado_oe,
    output logic                     ras,
    output logic                     cas,
    output logic                     access_done
);

    // Reject illegal timing or geometry at elaboration
    if (!(T_ROW >= 0 && T_ROW < T_RAS && T_RAS < T_MUX && T_MUX < T_CAS
          && T_CAS < T_REL && T_REL <= 15)) begin : g_bad_timing
        $error("vic_dram_seq: timing must be strictly increasing with T_REL <= 15");
    end
    if (NUM_SPRITES < 1 || NUM_SPRITES > 16) begin : g_bad_sprites
        $error("vic_dram_seq: NUM_SPRITES must be 1..16");
    end
    if (ADO_W < 8 || ADO_W > 14) begin : g_bad_ado_w
        $error("vic_dram_seq: ADO_W must be 8..14");
    end

    localparam logic [3:0] TK_ROW = 4'(T_ROW);
    localparam logic [3:0] TK_RAS = 4'(T_RAS);
    localparam logic [3:0] TK_MUX = 4'(T_MUX);
    localparam logic [3:0] TK_CAS = 4'(T_CAS);
    localparam logic [3:0] TK_REL = 4'(T_REL);

    logic [13:0] addr_now;

    vic_addr_compose #(
        .NUM_SPRITES (NUM_SPRITES),
        .SPR_IDX_W   (SPR_IDX_W)
    ) u_compose (
        .cycle_type   (cycle_type),
        .cb           (cb),
        .vm           (vm),
        .vc           (vc),
        .rc           (rc),
        .refc         (refc),
        .char_ptr     (char_ptr),
        .bmm          (bmm),
        .ecm          (ecm),
        .idle         (idle),
        .aec          (aec),
        .sprite_cnt   (sprite_cnt),
        .sprite_ptr_o (sprite_ptr_o),
        .sprite_mc_o  (sprite_mc_o),
        .addr         (addr_now)
    );

    seq_state_e       state_q, state_d;
    logic [3:0]       tick_q, tick_d;
    logic [13:0]      addr_lat_q, addr_lat_d;
    logic             refr_q, refr_d;
    logic             own_q, own_d;
    logic [ADO_W-1:0] ado_q, ado_d;
    logic             ado_oe_q, ado_oe_d;
    logic             ras_q, ras_d;
    logic             cas_q, cas_d;
    logic             done_q, done_d;

    // Next-state for tick counter, access FSM and the registered pin outputs
    always_comb begin
        state_d    = state_q;
        addr_lat_d = addr_lat_q;
        refr_d     = refr_q;
        own_d      = own_q;
        ado_d      = ado_q;
        ado_oe_d   = ado_oe_q;
        ras_d      = ras_q;
        cas_d      = cas_q;
        done_d     = 1'b0;
        tick_d     = phi_phase_start ? 4'd0 : ((tick_q == 4'd15) ? 4'd15 : tick_q + 4'd1);

        if (phi_phase_start) begin
            // A new half always restarts the sequence; an access in flight is abandoned
            ras_d   = 1'b1;
            cas_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick_q == TK_ROW) begin
                        addr_lat_d = addr_now;
                        refr_d     = (cycle_type == VIC_LR);
                        own_d      = !aec;
                        ado_oe_d   = !aec;
                        if (!aec) begin
                            ado_d = addr_now[ADO_W-1:0];
                        end
                        state_d = S_ROW;
                    end
                end
                S_ROW: begin
                    if (tick_q == TK_RAS) begin
                        ras_d   = 1'b0;
                        state_d = S_RAS;
                    end
                end
                S_RAS: begin
                    if (tick_q == TK_MUX) begin
                        if (own_q) begin
                            ado_d[7:0] = col_byte(addr_lat_q);
                        end
                        state_d = S_COL;
                    end
                end
                S_COL: begin
                    if (tick_q == TK_CAS) begin
                        if (!(refr_q && (RAS_ONLY_REFRESH != 0) && own_q)) begin
                            cas_d = 1'b0;
                        end
                        state_d = S_CAS;
                    end
                end
                S_CAS: begin
                    if (tick_q == TK_REL) begin
                        ras_d   = 1'b1;
                        cas_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD:  state_d = S_HOLD;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= 4'd15;
            addr_lat_q <= '1;
            refr_q     <= 1'b0;
            own_q      <= 1'b0;
            ado_q      <= '1;
            ado_oe_q   <= 1'b0;
            ras_q      <= 1'b1;
            cas_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            addr_lat_q <= addr_lat_d;
            refr_q     <= refr_d;
            own_q      <= own_d;
            ado_q      <= ado_d;
            ado_oe_q   <= ado_oe_d;
            ras_q      <= ras_d;
            cas_q      <= cas_d;
            done_q     <= done_d;
        end
    end

    assign ado         = ado_q;
    assign ado_oe      = ado_oe_q;
    assign ras         = ras_q;
    assign cas         = cas_q;
    assign access_done = done_q;

endmodule

// File: tb/tb_vic_dram_seq.sv
// Self-checking bench for vic_dram_seq: directed accesses with literal
// expectations plus randomized traffic checked every cycle against a
// tick-position model of the DRAM access.
module tb_vic_dram_seq;
    import vic_dram_seq_pkg::*;

    localparam int NS   = 16;
    localparam int SW   = 4;
    localparam int AW   = 12;
    localparam int TR   = 2;
    localparam int TRAS = 5;
    localparam int TM   = 6;
    localparam int TC   = 7;
    localparam int TREL = 14;
    localparam int ROR  = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            phi;
    logic [3:0]      cycle_type;
    logic [2:0]      cb;
    logic [3:0]      vm;
    logic [9:0]      vc;
    logic [2:0]      rc;
    logic [7:0]      refc;
    logic [7:0]      char_ptr;
    logic            bmm, ecm, idle, aec;
    logic [SW-1:0]   sprite_cnt;
    logic [NS*8-1:0] sprite_ptr_o;
    logic [NS*6-1:0] sprite_mc_o;
    logic [AW-1:0]   ado;
    logic            ado_oe, ras, cas, access_done;

    always #5 clk = ~clk;

    vic_dram_seq #(
        .NUM_SPRITES      (NS),
        .ADO_W            (AW),
        .T_ROW            (TR),
        .T_RAS            (TRAS),
        .T_MUX            (TM),
        .T_CAS            (TC),
        .T_REL            (TREL),
        .RAS_ONLY_REFRESH (ROR)
    ) dut (
        .clk_dot4x       (clk),
        .rst             (rst),
        .phi_phase_start (phi),
        .cycle_type      (cycle_type),
        .cb              (cb),
        .vm              (vm),
        .vc              (vc),
        .rc              (rc),
        .refc            (refc),
        .char_ptr        (char_ptr),
        .bmm             (bmm),
        .ecm             (ecm),
        .idle            (idle),
        .aec             (aec),
        .sprite_cnt      (sprite_cnt),
        .sprite_ptr_o    (sprite_ptr_o),
        .sprite_mc_o     (sprite_mc_o),
        .ado             (ado),
        .ado_oe          (ado_oe),
        .ras             (ras),
        .cas             (cas),
        .access_done     (access_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: position within the current half and the outputs it implies
    bit          started = 0;
    int          k = 0;
    logic [13:0] m_a = '1;
    bit          m_own = 0;
    bit          m_refr = 0;
    logic [11:0] m_ado = '1;
    logic        m_oe = 0, m_ras = 1, m_cas = 1, m_done = 0;

    int ras_low, cas_low, done_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address the specification asks for, built with plain arithmetic
    function automatic logic [13:0] model_addr();
        int          sc;
        int          v;
        logic [127:0] pt;
        logic [95:0]  mt;
        sc = int'(sprite_cnt);
        v  = 'h3FFF;
        case (cycle_type)
            VIC_LR: v = 'h3F00 + int'(refc);
            VIC_LG: begin
                if (idle) v = ecm ? 'h39FF : 'h3FFF;
                else begin
                    if (bmm) v = (int'(cb[2]) << 13) + (int'(vc) << 3) + int'(rc);
                    else     v = (int'(cb) << 11) + (int'(char_ptr) << 3) + int'(rc);
                    if (ecm) v = v & ~'h600;
                end
            end
            VIC_HRC, VIC_HGC: v = (int'(vm) << 10) + int'(vc);
            VIC_LP: if (sc < NS) v = (int'(vm) << 10) + ('h7F << 3) + (sc % 8);
            VIC_HS1, VIC_LS2, VIC_HS3: begin
                if (sc < NS && !aec) begin
                    pt = sprite_ptr_o >> ((NS - 1 - sc) * 8);
                    mt = sprite_mc_o >> ((NS - 1 - sc) * 6);
                    v  = (int'(pt[7:0]) << 6) + int'(mt[5:0]);
                end
            end
            default: v = 'h3FFF;
        endcase
        return v[13:0];
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic step();
        int t;
        @(posedge clk);
        if (rst) begin
            started = 0;
            m_ado = '1; m_oe = 0; m_ras = 1; m_cas = 1; m_done = 0;
        end else if (phi) begin
            started = 1; k = 0;
            m_ras = 1; m_cas = 1; m_done = 0;
        end else if (started) begin
            t = k;
            if (t == TR) begin
                m_a    = model_addr();
                m_own  = !aec;
                m_refr = (cycle_type == VIC_LR);
                m_oe   = m_own;
                if (m_own) m_ado = m_a[11:0];
            end
            if (t == TM && m_own) m_ado[7:0] = {m_a[7:6], m_a[13:8]};
            m_ras  = !(t >= TRAS && t < TREL);
            m_cas  = !(t >= TC && t < TREL && !(ROR != 0 && m_refr && m_own));
            m_done = (t == TREL);
            if (k < 15) k++;
        end else begin
            m_done = 0;
        end
        #1;
        chk("ado", 32'(ado), 32'(m_ado));
        chk("ado_oe", 32'(ado_oe), 32'(m_oe));
        chk("ras", 32'(ras), 32'(m_ras));
        chk("cas", 32'(cas), 32'(m_cas));
        chk("access_done", 32'(access_done), 32'(m_done));
        if (!ras) ras_low++;
        if (!cas) cas_low++;
        if (access_done) done_n++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_cnt();
        ras_low = 0; cas_low = 0; done_n = 0;
    endtask

    // Change every address input so late changes can be seen to be ignored
    task automatic scramble();
        cycle_type = 4'($urandom); cb = 3'($urandom); vm = 4'($urandom);
        vc = 10'($urandom); rc = 3'($urandom); refc = 8'($urandom);
        char_ptr = 8'($urandom); bmm = 1'($urandom); ecm = 1'($urandom);
        idle = 1'($urandom); sprite_cnt = SW'($urandom);
    endtask

    // Full half phase: optional phi pulse, then capture row and column addresses
    task automatic run_half(input string tag, input bit do_phi,
                            output logic [11:0] row, output logic [11:0] col);
        if (do_phi) begin
            phi = 1; step(); phi = 0;
        end
        clr_cnt();
        steps(TR + 1);
        row = ado;
        scramble();
        steps(TM - TR);
        col = ado;
        steps(12);
        $display("access %s: row=%03h col=%03h oe=%0d ras_low=%0d cas_low=%0d done=%0d",
                 tag, row, col, ado_oe, ras_low, cas_low, done_n);
    endtask

    logic [11:0] row, col;
    int          half_len, half_cnt;

    initial begin
        rst = 1; phi = 0; cycle_type = VIC_HI; cb = 0; vm = 0; vc = 0; rc = 0;
        refc = 0; char_ptr = 0; bmm = 0; ecm = 0; idle = 0; aec = 0; sprite_cnt = 0;
        sprite_ptr_o = '0; sprite_mc_o = '0;
        clr_cnt();

        // Reset state
        steps(2);
        chk("reset_ado", 32'(ado), 32'h0FFF);
        chk("reset_oe", 32'(ado_oe), 32'h0);
        chk("reset_ras_cas", 32'({ras, cas, access_done}), 32'b110);
        rst = 0;
        steps(3);
        chk("no_phi_idle", 32'({ras, cas, ado_oe}), 32'b110);

        // RAS-only refresh
        cycle_type = VIC_LR; refc = 8'h5A; aec = 0;
        run_half("refresh", 1, row, col);
        chk("lr_row", 32'(row), 32'h0F5A);
        chk("lr_col", 32'(col), 32'h0F7F);
        chk("lr_ras_low", 32'(ras_low), 32'd9);
        chk("lr_cas_low", 32'(cas_low), 32'd0);
        chk("lr_done", 32'(done_n), 32'd1);

        // Bitmap + ECM graphics fetch
        cycle_type = VIC_LG; bmm = 1; ecm = 1; cb = 3'b100; vc = 10'h3FF; rc = 3'd7;
        idle = 0; aec = 0;
        run_half("bmm_ecm", 1, row, col);
        chk("lg_row", 32'(row), 32'h09FF);
        chk("lg_col", 32'(col), 32'h09F9);
        chk("lg_cas_low", 32'(cas_low), 32'd7);
        chk("lg_done", 32'(done_n), 32'd1);

        // Sprite fetch for sprite 12
        for (int i = 0; i < NS; i++) begin
            sprite_ptr_o[i*8 +: 8] = 8'($urandom);
            sprite_mc_o[i*6 +: 6]  = 6'($urandom);
        end
        sprite_ptr_o[(NS-1-12)*8 +: 8] = 8'hC3;
        sprite_mc_o[(NS-1-12)*6 +: 6]  = 6'h15;
        cycle_type = VIC_HS1; aec = 0; sprite_cnt = 4'd12;
        run_half("sprite", 1, row, col);
        chk("spr_row", 32'(row), 32'h00D5);
        chk("spr_col", 32'(col), 32'h00F0);

        // CPU phase: bus not owned, strobes still run
        cycle_type = VIC_HS3; aec = 1;
        run_half("cpu", 1, row, col);
        chk("cpu_row_hold", 32'(row), 32'h00F0);
        chk("cpu_col_hold", 32'(col), 32'h00F0);
        chk("cpu_oe", 32'(ado_oe), 32'h0);
        chk("cpu_ras_low", 32'(ras_low), 32'd9);
        chk("cpu_cas_low", 32'(cas_low), 32'd7);
        chk("cpu_done", 32'(done_n), 32'd1);

        // Abort: new half starts while CAS is low
        cycle_type = VIC_HRC; vm = 4'hA; vc = 10'h155; aec = 0;
        phi = 1; step(); phi = 0;
        clr_cnt();
        steps(9);
        chk("abort_pre_cas", 32'(cas), 32'h0);
        cycle_type = VIC_LP; vm = 4'h5; sprite_cnt = 4'd3;
        phi = 1; step(); phi = 0;
        chk("abort_ras_cas", 32'({ras, cas, access_done}), 32'b110);
        chk("abort_no_done", 32'(done_n), 32'd0);
        run_half("after_abort", 0, row, col);
        chk("abort_new_row", 32'(row), 32'h07FB);
        chk("abort_new_col", 32'(col), 32'h07D7);

        // Reset in the middle of an access
        cycle_type = VIC_LR; refc = 8'h33; aec = 0;
        phi = 1; step(); phi = 0;
        steps(8);
        rst = 1; step(); rst = 0;
        chk("midrst_ado", 32'(ado), 32'h0FFF);
        chk("midrst_pins", 32'({ado_oe, ras, cas}), 32'b011);
        steps(4);
        run_half("after_reset", 1, row, col);
        chk("midrst_row", 32'(row), 32'h0F33);
        chk("midrst_col", 32'(col), 32'h0F3F);
        chk("midrst_done", 32'(done_n), 32'd1);

        // Randomized traffic: regular halves, early restarts, long gaps, rare resets
        half_len = 16; half_cnt = 16;
        for (int i = 0; i < 4000; i++) begin
            scramble();
            if (cycle_type[3] && $urandom_range(0, 1) == 0) cycle_type[3] = 1'b0;
            aec = 1'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                for (int s = 0; s < NS; s++) begin
                    sprite_ptr_o[s*8 +: 8] = 8'($urandom);
                    sprite_mc_o[s*6 +: 6]  = 6'($urandom);
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            phi = 0;
            if (half_cnt >= half_len) begin
                phi = 1;
                half_cnt = 0;
                case ($urandom_range(0, 7))
                    0:       half_len = $urandom_range(1, 15);
                    1:       half_len = $urandom_range(17, 30);
                    default: half_len = 16;
                endcase
            end
            half_cnt++;
            step();
        end
        rst = 0; phi = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
